muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, watchdog limit in cycles while an operation is running.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_mult  input  1  request a MULT; sampled in IDLE only.
REQ-005 SHALL have port start_div  input  1  request a DIV; sampled in IDLE only.
REQ-006 SHALL have port divisor_zero  input  1  divisor operand equals zero; sampled with start_div.
REQ-007 SHALL have port mult_done  input  1  multiplier result valid.
REQ-008 SHALL have port div_done  input  1  divider result valid.
REQ-009 SHALL have port mult_go  output  1  one-cycle start pulse to the multiplier.
REQ-010 SHALL have port div_go  output  1  one-cycle start pulse to the divider.
REQ-011 SHALL have port div_ctrl  output  1  HI/LO source select: 0 = divider, 1 = multiplier.
REQ-012 SHALL have port hilo_write  output  1  one-cycle HI/LO register write enable.
REQ-013 SHALL have port busy  output  1  stall request to the main control unit.
REQ-014 SHALL have port div_zero_err  output  1  one-cycle divide-by-zero exception pulse.
REQ-015 SHALL have port timeout_err  output  1  one-cycle watchdog exception pulse (feature-gated, see Configuration).

Function
REQ-016 SHALL implement the states IDLE, MULT_RUN, DIV_RUN and WRITE.
REQ-017 IDLE with start_mult=1 SHALL pulse mult_go, set div_ctrl=1 and enter MULT_RUN on the next edge.
REQ-018 IDLE with start_div=1 and start_mult=0 SHALL do one of two things: with divisor_zero=0, pulse div_go, set div_ctrl=0 and enter DIV_RUN; with divisor_zero=1, pulse div_zero_err, stay in IDLE, issue no div_go and no hilo_write.
REQ-019 When start_mult and start_div are asserted together, the block SHALL start the MULT and ignore the DIV request; no error is raised.
REQ-020 go pulses SHALL be combinational from IDLE plus the start input, so the unit starts in the same cycle as the request.
REQ-021 MULT_RUN SHALL go to WRITE on the edge where mult_done=1; div_done SHALL be ignored in this state.
REQ-022 DIV_RUN SHALL go to WRITE on the edge where div_done=1; mult_done SHALL be ignored in this state.
REQ-023 WRITE SHALL assert hilo_write for exactly one cycle and then return to IDLE.
REQ-024 div_ctrl SHALL be registered and held stable from the go cycle through the WRITE cycle inclusive.
REQ-025 busy SHALL be 1 in MULT_RUN, DIV_RUN and WRITE, and in the IDLE cycle that issues a go.
REQ-026 busy SHALL be 0 otherwise.
REQ-027 Start inputs SHALL be ignored while not in IDLE.
REQ-028 A new request in the cycle after WRITE SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-029 Minimum latency from go to hilo_write SHALL be 2 cycles (done returned in the cycle after go).

Reset
REQ-030 reset=0 SHALL immediately force IDLE and zero the watchdog counter.
REQ-031 reset=0 SHALL immediately drive mult_go=0, div_go=0, hilo_write=0, busy=0, div_zero_err=0, timeout_err=0 and div_ctrl=0.
REQ-032 Reset during MULT_RUN, DIV_RUN or WRITE SHALL abort the operation with no hilo_write.
REQ-033 Any done arriving after reset deassertion SHALL be ignored in IDLE.

Configuration
REQ-034 Macro MULDIV_TIMEOUT_EN defined: a counter SHALL clear on go and increment each cycle in MULT_RUN or DIV_RUN.
REQ-035 MULDIV_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES without done, the block SHALL pulse timeout_err for one cycle, return to IDLE and issue no hilo_write.
REQ-036 MULDIV_TIMEOUT_EN defined: done arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL take priority, going to WRITE with no error.
REQ-037 MULDIV_TIMEOUT_EN undefined: the counter SHALL be absent, timeout_err SHALL be tied to 0, and the run states SHALL wait indefinitely.

Verification
REQ-038 The bench SHALL cover MULT: start_mult=1 in cycle 0, mult_done=1 in cycle 5 -> mult_go pulse in cycle 0, div_ctrl=1 held, hilo_write in cycle 6 only, busy in cycles 0-6.
REQ-039 The bench SHALL cover DIV with divisor_zero=1: start_div=1 -> div_zero_err pulse, div_go=0, busy=0, state remains IDLE.
REQ-040 The bench SHALL cover simultaneous requests: start_mult=start_div=1 -> mult_go only, div_ctrl=1, div_go never asserted.
REQ-041 The bench SHALL cover reset mid-run: start_div, reset=0 in cycle 3, div_done=1 in cycle 6 -> outputs zero immediately, no hilo_write at any time.
REQ-042 The bench SHALL cover the watchdog with MULDIV_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: start_div, no div_done -> timeout_err pulse after 8 run cycles, then IDLE, no hilo_write.
REQ-043 The bench SHALL cover the watchdog boundary with MULDIV_TIMEOUT_EN defined and TIMEOUT_CYCLES=8: div_done arriving on the 8th run cycle -> WRITE, no timeout_err.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller for the multiplier/divider units and the HI/LO write
// Ports: clk; reset (async, active-low); start_mult/start_div/divisor_zero requests from decode;
//   mult_done/div_done from the units; mult_go/div_go start pulses; div_ctrl HI/LO source
//   select (1 = multiplier, 0 = divider); hilo_write; busy stall; div_zero_err and
//   timeout_err exception pulses.
// Define MULDIV_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog on the run states.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic divisor_zero,
  input  logic mult_done,
  input  logic div_done,
  output logic mult_go,
  output logic div_go,
  output logic div_ctrl,
  output logic hilo_write,
  output logic busy,
  output logic div_zero_err,
  output logic timeout_err
);
  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, WRITE} state_t;
  state_t state_q, state_d;
  logic div_ctrl_q, div_ctrl_d;
  logic idle, done, tmo;
  // Request pulses are combinational so the unit starts in the request cycle; reset masks them.
  assign idle         = reset && state_q == IDLE;
  assign mult_go      = idle && start_mult;
  assign div_go       = idle && start_div && !start_mult && !divisor_zero;
  assign div_zero_err = idle && start_div && !start_mult && divisor_zero;
  assign done         = (state_q == MULT_RUN && mult_done) || (state_q == DIV_RUN && div_done);
  assign hilo_write   = state_q == WRITE;
  assign busy         = state_q != IDLE || mult_go || div_go;
  // Registered select, bypassed in the go cycle so it is valid from the moment the unit starts.
  assign div_ctrl     = mult_go || (!div_go && div_ctrl_q);
  always_comb begin
    div_ctrl_d = div_ctrl;
    state_d    = mult_go ? MULT_RUN : div_go ? DIV_RUN : hilo_write ? IDLE :
                 done ? WRITE : tmo ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_ctrl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_ctrl_q <= div_ctrl_d;
    end
  end
`ifdef MULDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, run;
  assign run         = state_q == MULT_RUN || state_q == DIV_RUN;
  // Expires on the run cycle that brings the count to TIMEOUT_CYCLES; a done in that cycle wins.
  assign tmo         = run && !done && cnt_q == CNT_LAST;
  assign timeout_err = tmo_q;
  always_comb begin
    cnt_d = (mult_go || div_go) ? '0 : run ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with a HI/LO write scoreboard
module tb_muldiv_ctrl;
  logic clk, reset, start_mult, start_div, divisor_zero, mult_done, div_done;
  logic mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err;
  int n_cmp, n_err, cyc, s_cyc;
  logic o_mgo, o_dgo, o_ctrl, o_wr, o_busy, o_dze, o_tmo;
  typedef struct { logic ctrl; int wcyc; } exp_t;
  exp_t sb[$];

  muldiv_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .divisor_zero(divisor_zero), .mult_done(mult_done), .div_done(div_done),
    .mult_go(mult_go), .div_go(div_go), .div_ctrl(div_ctrl), .hilo_write(hilo_write),
    .busy(busy), .div_zero_err(div_zero_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1: samples at the falling edge, checks writes against the scoreboard,
  // snapshots outputs for the caller, then advances to the next posedge+1.
  task automatic cycle();
    exp_t e;
    #4;
    s_cyc = cyc;
    {o_mgo, o_dgo, o_ctrl, o_wr, o_busy, o_dze, o_tmo} =
      {mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err};
    if (hilo_write === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: hilo_write=1 at cycle %0d, no write expected", cyc);
      end else begin
        e = sb.pop_front();
        if (div_ctrl !== e.ctrl || cyc !== e.wcyc) begin
          n_err++;
          $display("FAIL sb_write: got div_ctrl=%b cycle=%0d, expected div_ctrl=%b cycle=%0d",
                   div_ctrl, cyc, e.ctrl, e.wcyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    {start_mult, start_div, divisor_zero, mult_done, div_done} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    start_mult = 1'b1;
    #2;
    n_cmp++;
    if ({mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err});
    end
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    reset = 1'b1;
    cycle();
    n_cmp++;
    if (o_busy !== 1'b0 || o_wr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b hilo_write=%b, expected 0 0", o_busy, o_wr);
    end
  endtask

  task automatic test_mult();
    start_mult = 1'b1;
    sb.push_back('{1'b1, cyc + 6});
    cycle();
    start_mult = 1'b0;
    n_cmp++;
    if ({o_mgo, o_dgo, o_ctrl, o_busy} !== 4'b1011) begin
      n_err++;
      $display("FAIL mult_go_cycle: mgo,dgo,ctrl,busy=%b expected 1011", {o_mgo, o_dgo, o_ctrl, o_busy});
    end
    for (int k = 1; k <= 7; k++) begin
      mult_done = (k == 5);
      div_done  = (k == 3);
      start_div = (k == 2);
      cycle();
      n_cmp++;
      if ({o_mgo, o_dgo, o_ctrl, o_busy, o_wr} !== {2'b00, 1'b1, k <= 6, k == 6}) begin
        n_err++;
        $display("FAIL mult_run_k%0d: mgo,dgo,ctrl,busy,wr=%b expected %b", k,
                 {o_mgo, o_dgo, o_ctrl, o_busy, o_wr}, {2'b00, 1'b1, k <= 6, k == 6});
      end
    end
    idle_inputs();
  endtask

  task automatic test_div();
    start_div = 1'b1;
    divisor_zero = 1'b1;
    cycle();
    n_cmp++;
    if ({o_dze, o_dgo, o_mgo, o_busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL div_zero: dze,dgo,mgo,busy=%b expected 1000", {o_dze, o_dgo, o_mgo, o_busy});
    end
    divisor_zero = 1'b0;
    sb.push_back('{1'b0, cyc + 3});
    cycle();
    start_div = 1'b0;
    n_cmp++;
    if ({o_dze, o_dgo, o_ctrl, o_busy} !== 4'b0101) begin
      n_err++;
      $display("FAIL div_go_after_zero: dze,dgo,ctrl,busy=%b expected 0101", {o_dze, o_dgo, o_ctrl, o_busy});
    end
    mult_done = 1'b1;
    cycle();
    mult_done = 1'b0;
    div_done = 1'b1;
    cycle();
    div_done = 1'b0;
    n_cmp++;
    if ({o_busy, o_ctrl, o_wr} !== 3'b100) begin
      n_err++;
      $display("FAIL div_run: busy,ctrl,wr=%b expected 100", {o_busy, o_ctrl, o_wr});
    end
    cycle();
    n_cmp++;
    if ({o_wr, o_busy, o_ctrl} !== 3'b110) begin
      n_err++;
      $display("FAIL div_write: wr,busy,ctrl=%b expected 110", {o_wr, o_busy, o_ctrl});
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    {start_mult, start_div, divisor_zero} = 3'b111;
    sb.push_back('{1'b1, cyc + 2});
    cycle();
    {start_mult, start_div, divisor_zero} = 3'b000;
    n_cmp++;
    if ({o_mgo, o_dgo, o_ctrl, o_dze} !== 4'b1010) begin
      n_err++;
      $display("FAIL simul_req: mgo,dgo,ctrl,dze=%b expected 1010", {o_mgo, o_dgo, o_ctrl, o_dze});
    end
    mult_done = 1'b1;
    cycle();
    mult_done = 1'b0;
    start_div = 1'b1;
    cycle();
    n_cmp++;
    if ({o_wr, o_dgo, o_ctrl} !== 3'b101) begin
      n_err++;
      $display("FAIL write_ignores_start: wr,dgo,ctrl=%b expected 101", {o_wr, o_dgo, o_ctrl});
    end
    sb.push_back('{1'b0, cyc + 2});
    cycle();
    start_div = 1'b0;
    n_cmp++;
    if ({o_dgo, o_ctrl, o_busy} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_div_go: dgo,ctrl,busy=%b expected 101", {o_dgo, o_ctrl, o_busy});
    end
    div_done = 1'b1;
    cycle();
    div_done = 1'b0;
    cycle();
    cycle();
    n_cmp++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    start_div = 1'b1;
    cycle();
    start_div = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if ({mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: outputs=%b expected 0000000",
               {mult_go, div_go, div_ctrl, hilo_write, busy, div_zero_err, timeout_err});
    end
    for (int k = 3; k <= 8; k++) begin
      if (k == 4) reset = 1'b1;
      div_done = (k == 6);
      cycle();
      n_cmp++;
      if (o_wr !== 1'b0 || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_abort_k%0d: wr=%b busy=%b expected 0 0", k, o_wr, o_busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
`ifdef MULDIV_TIMEOUT_EN
    start_div = 1'b1;
    cycle();
    start_div = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_cmp++;
      if ({o_tmo, o_busy, o_wr} !== {k == 9, k <= 8, 1'b0}) begin
        n_err++;
        $display("FAIL watchdog_k%0d: tmo,busy,wr=%b expected %b", k, {o_tmo, o_busy, o_wr},
                 {k == 9, k <= 8, 1'b0});
      end
    end
    start_div = 1'b1;
    sb.push_back('{1'b0, cyc + 9});
    cycle();
    start_div = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      div_done = (k == 8);
      cycle();
      n_cmp++;
      if ({o_tmo, o_busy} !== {1'b0, k <= 9}) begin
        n_err++;
        $display("FAIL watchdog_edge_k%0d: tmo,busy=%b expected %b", k, {o_tmo, o_busy}, {1'b0, k <= 9});
      end
    end
    div_done = 1'b0;
`else
    start_div = 1'b1;
    sb.push_back('{1'b0, cyc + 22});
    cycle();
    start_div = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      div_done = (k == 21);
      cycle();
      n_cmp++;
      if ({o_tmo, o_busy} !== {1'b0, k <= 22}) begin
        n_err++;
        $display("FAIL no_watchdog_k%0d: tmo,busy=%b expected %b", k, {o_tmo, o_busy}, {1'b0, k <= 22});
      end
    end
    div_done = 1'b0;
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid_run();
    test_watchdog();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drained: %0d writes still pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
